// File: rtl/pkt_framer.sv
// Packet framing source: emits a length header, a pass-through payload and an
// XOR-checksum tail under a valid/ready handshake, with head/tail frame markers.
module pkt_framer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              valid,
  output logic              head,
  output logic              tail,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAD = 2'b01,
    DATA = 2'b10,
    TAIL = 2'b11
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] csum;

  logic xfer;
  assign xfer = in_valid && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      len_q     <= '0;
      csum      <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q     <= len;
            remaining <= len;
            csum      <= '0;
            state     <= HEAD;
          end
        end
        HEAD: begin
          if (out_ready) state <= (len_q == '0) ? TAIL : DATA;
        end
        DATA: begin
          if (xfer) begin
            csum      <= csum ^ in_data;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= TAIL;
          end
        end
        TAIL: begin
          if (out_ready) begin
            state     <= IDLE;
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from state so HEAD/TAIL words stay stable under stall.
  always_comb begin
    valid    = 1'b0;
    head     = 1'b0;
    tail     = 1'b0;
    in_ready = 1'b0;
    data     = '0;
    busy     = (state != IDLE);
    case (state)
      HEAD: begin
        valid = 1'b1;
        head  = 1'b1;
        data  = DATA_W'(len_q);
      end
      DATA: begin
        valid    = in_valid;
        data     = in_data;
        in_ready = out_ready;
      end
      TAIL: begin
        valid = 1'b1;
        tail  = 1'b1;
        data  = csum;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pkt_framer.sv
// Directed self-checking bench for pkt_framer with hand-computed expected words.
module tb_pkt_framer;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_ready;
  logic       valid;
  logic       head;
  logic       tail;
  logic [7:0] data;
  logic       busy;
  logic [7:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  pkt_framer #(.DATA_W(8), .LEN_W(4), .CNT_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .valid     (valid),
    .head      (head),
    .tail      (tail),
    .data      (data),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed as {valid, head, tail, in_ready, busy, data}.
  task automatic expect_out(input string tag, input logic v, input logic h, input logic t,
                            input logic ir, input logic b, input logic [7:0] d);
    #1;
    chk(tag, {19'd0, valid, head, tail, in_ready, busy, data}, {19'd0, v, h, t, ir, b, d});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    expect_out("reset_outs", 0, 0, 0, 0, 0, 8'h00);
    chk("reset_cnt", {24'd0, frame_cnt}, 32'd0);
    #10 reset = 1'b0;
    cyc();

    // Frame 1: len 3, payload 11 22 44, tail 77
    start = 1'b1; len = 4'd3; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    expect_out("f1_idle", 0, 0, 0, 0, 0, 8'h00);
    cyc(); start = 1'b0;
    expect_out("f1_head", 1, 1, 0, 0, 1, 8'h03);
    cyc();
    expect_out("f1_d0", 1, 0, 0, 1, 1, 8'h11);
    cyc(); in_data = 8'h22;
    expect_out("f1_d1", 1, 0, 0, 1, 1, 8'h22);
    cyc(); in_data = 8'h44;
    expect_out("f1_d2", 1, 0, 0, 1, 1, 8'h44);
    cyc(); in_valid = 1'b0;
    expect_out("f1_tail", 1, 0, 1, 0, 1, 8'h77);
    cyc();
    expect_out("f1_done", 0, 0, 0, 0, 0, 8'h00);
    chk("f1_cnt", {24'd0, frame_cnt}, 32'd1);

    // Frame 2: len 0 -> header 00 then tail 00
    start = 1'b1; len = 4'd0;
    cyc(); start = 1'b0;
    expect_out("f2_head", 1, 1, 0, 0, 1, 8'h00);
    cyc();
    expect_out("f2_tail", 1, 0, 1, 0, 1, 8'h00);
    cyc();
    expect_out("f2_done", 0, 0, 0, 0, 0, 8'h00);
    chk("f2_cnt", {24'd0, frame_cnt}, 32'd2);

    // Frame 3: len 2 with stalls and source gaps; tail 3C^96 = AA
    start = 1'b1; len = 4'd2; out_ready = 1'b0;
    cyc(); start = 1'b0;
    expect_out("f3_head_stall0", 1, 1, 0, 0, 1, 8'h02);
    cyc();
    expect_out("f3_head_stall1", 1, 1, 0, 0, 1, 8'h02);
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; in_data = 8'hA5;
    expect_out("f3_gap", 0, 0, 0, 1, 1, 8'hA5);
    cyc();
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0;
    expect_out("f3_d0_stall", 1, 0, 0, 0, 1, 8'h3C);
    cyc(); out_ready = 1'b1;
    expect_out("f3_d0", 1, 0, 0, 1, 1, 8'h3C);
    cyc();
    in_data = 8'h96; out_ready = 1'b0;
    expect_out("f3_d1_stall", 1, 0, 0, 0, 1, 8'h96);
    cyc(); out_ready = 1'b1;
    expect_out("f3_d1", 1, 0, 0, 1, 1, 8'h96);
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    expect_out("f3_tail_stall0", 1, 0, 1, 0, 1, 8'hAA);
    cyc();
    expect_out("f3_tail_stall1", 1, 0, 1, 0, 1, 8'hAA);
    out_ready = 1'b1; start = 1'b1;
    cyc();
    expect_out("f3_start_in_tail_ignored", 0, 0, 0, 0, 0, 8'h00);
    chk("f3_cnt", {24'd0, frame_cnt}, 32'd3);
    start = 1'b0;

    // Frame 4: len 4, start pulsed in DATA is ignored; tail 01^02^04^08 = 0F
    start = 1'b1; len = 4'd4; in_valid = 1'b1; in_data = 8'h01;
    cyc(); start = 1'b0;
    cyc(); start = 1'b1; len = 4'd2;
    expect_out("f4_d0", 1, 0, 0, 1, 1, 8'h01);
    cyc(); start = 1'b0; in_data = 8'h02;
    cyc(); in_data = 8'h04;
    cyc(); in_data = 8'h08;
    expect_out("f4_d3", 1, 0, 0, 1, 1, 8'h08);
    cyc(); in_valid = 1'b0;
    expect_out("f4_tail", 1, 0, 1, 0, 1, 8'h0F);
    cyc();
    cyc();
    expect_out("f4_idle", 0, 0, 0, 0, 0, 8'h00);
    chk("f4_cnt", {24'd0, frame_cnt}, 32'd4);

    // Reset in DATA after one of three words
    start = 1'b1; len = 4'd3; in_valid = 1'b1; in_data = 8'h10;
    cyc(); start = 1'b0;
    cyc();
    cyc();
    expect_out("f5_mid", 1, 0, 0, 1, 1, 8'h10);
    reset = 1'b1;
    expect_out("f5_reset_async", 0, 0, 0, 0, 0, 8'h00);
    chk("f5_reset_cnt", {24'd0, frame_cnt}, 32'd0);
    cyc(); reset = 1'b0;
    start = 1'b1; len = 4'd1; in_data = 8'h5A;
    cyc(); start = 1'b0;
    expect_out("f6_head", 1, 1, 0, 0, 1, 8'h01);
    cyc();
    expect_out("f6_d0", 1, 0, 0, 1, 1, 8'h5A);
    cyc(); in_valid = 1'b0;
    expect_out("f6_tail", 1, 0, 1, 0, 1, 8'h5A);
    cyc();
    chk("f6_cnt", {24'd0, frame_cnt}, 32'd1);

    // Back-to-back len 0 frames, 3 cycles each, to wrap the counter
    start = 1'b1; len = 4'd0;
    for (int i = 0; i < 254; i++) begin
      cyc(); cyc(); cyc();
    end
    expect_out("wrap_idle", 0, 0, 0, 0, 0, 8'h00);
    chk("wrap_255", {24'd0, frame_cnt}, 32'd255);
    cyc(); cyc(); cyc();
    start = 1'b0;
    chk("wrap_0", {24'd0, frame_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
